// File: rtl/mem_line_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_line_responder_pkg
// Shared C2 line-bus constants: command encodings and the default bus widths,
// line size and access latency used by the cache, the memory driver and the
// memory-side responder. Also holds a small command-decode helper.
// -----------------------------------------------------------------------------
package mem_line_responder_pkg;

  // C2 command encodings
  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  // Default geometry and timing
  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_LATENCY    = 100;

  // True only for the two request commands; NOP, RESPONSE, X and Z all fall
  // through to the default arm.
  function automatic logic is_request(input logic [1:0] cmd);
    case (cmd)
      C2_READ_LINE,
      C2_WRITE_LINE: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// -----------------------------------------------------------------------------
// mem_line_responder_if
// C2 line bus between an initiator (master) and the memory responder (slave).
//   addr_mem_w : line address, driven by the initiator
//   cmd_mem_w  : shared 2-bit command bus (tri-state)
//   data_mem_w : shared data bus (tri-state)
//   mst_*      : initiator-side drive enable / values
//   slv_*      : responder-side drive enable / values
// The tri-state resolution of both sides is done here so that each shared
// wire has all of its drivers in one place.
// -----------------------------------------------------------------------------
interface mem_line_responder_if
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] addr_mem_w;
  wire  [DATA_W-1:0] data_mem_w;
  wire  [1:0]        cmd_mem_w;

  logic              mst_drive;
  logic [1:0]        mst_cmd;
  logic [DATA_W-1:0] mst_data;

  logic              slv_drive;
  logic [1:0]        slv_cmd;
  logic [DATA_W-1:0] slv_data;

  assign cmd_mem_w  = mst_drive ? mst_cmd  : {2{1'bz}};
  assign cmd_mem_w  = slv_drive ? slv_cmd  : {2{1'bz}};
  assign data_mem_w = mst_drive ? mst_data : {DATA_W{1'bz}};
  assign data_mem_w = slv_drive ? slv_data : {DATA_W{1'bz}};

  modport master (
    output addr_mem_w, mst_drive, mst_cmd, mst_data,
    input  cmd_mem_w, data_mem_w, slv_drive
  );

  modport slave (
    input  addr_mem_w, cmd_mem_w, data_mem_w,
    output slv_drive, slv_cmd, slv_data
  );

endinterface

// File: rtl/mem_line_responder_ram.sv
// -----------------------------------------------------------------------------
// mem_line_ram
// Single-port line store: one synchronous line-wide write port and one
// combinational read port sharing the same address. No reset; contents
// survive a responder reset.
//   clk      : clock
//   i_addr   : line address (read and write)
//   i_we     : write enable
//   i_wdata  : full line to write
//   o_rdata  : full line at i_addr
// -----------------------------------------------------------------------------
module mem_line_ram #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Line write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
// Memory-side responder on the C2 line bus. Accepts READ_LINE / WRITE_LINE,
// waits a fixed LATENCY counted from the request edge, then answers with
// RESPONSE (plus BEATS data beats on a read, one cycle on a write).
//   clk         : clock, all sampling on posedge
//   reset       : asynchronous active-low reset
//   bus         : C2 bus, slave side
//   busy        : a request is held (state != IDLE)
//   read_count  : completed READ_LINE transactions (wraps)
//   write_count : completed WRITE_LINE transactions (wraps)
// -----------------------------------------------------------------------------
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  mem_line_responder_if.slave bus,
  output logic        busy,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_W / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RECV = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0] r_beat;
  logic [LINE_W-1:0] r_buf;
  logic              r_is_write;
  logic              r_busy;
  logic              r_drive;
  logic [1:0]        r_cmd;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_read_count;
  logic [31:0]       r_write_count;

  logic [LINE_W-1:0] w_rd_line;
  logic              w_lat_done;
  logic              w_we;

  assign w_lat_done = (r_cnt == CNT_W'(LATENCY));
  // The line is committed on the same edge that enters ACK.
  assign w_we       = (r_state == ST_WAIT) && w_lat_done && r_is_write;

  mem_line_ram #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (r_addr),
    .i_we    (w_we),
    .i_wdata (r_buf),
    .o_rdata (w_rd_line)
  );

  // Responder FSM: request capture, latency count, beat shifting, bus drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= {ADDR_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_beat        <= {BEAT_W{1'b0}};
      r_buf         <= {LINE_W{1'b0}};
      r_is_write    <= 1'b0;
      r_busy        <= 1'b0;
      r_drive       <= 1'b0;
      r_cmd         <= C2_NOP;
      r_data        <= {DATA_W{1'b0}};
      r_read_count  <= 32'd0;
      r_write_count <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (is_request(bus.cmd_mem_w)) begin
            r_addr <= bus.addr_mem_w;
            r_cnt  <= CNT_W'(1);
            r_busy <= 1'b1;
            if (bus.cmd_mem_w == C2_WRITE_LINE) begin
              r_is_write <= 1'b1;
              // Beats enter at the top and shift down, so beat 0 ends up
              // as the least-significant chunk after the last beat.
              r_buf      <= {bus.data_mem_w, r_buf[LINE_W-1:DATA_W]};
              r_beat     <= BEAT_W'(1);
              r_state    <= (BEATS == 1) ? ST_WAIT : ST_RECV;
            end else begin
              r_is_write <= 1'b0;
              r_state    <= ST_WAIT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RECV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_buf <= {bus.data_mem_w, r_buf[LINE_W-1:DATA_W]};
          if (r_beat == BEAT_W'(BEATS - 1)) begin
            r_beat  <= {BEAT_W{1'b0}};
            r_state <= ST_WAIT;
          end else begin
            r_beat  <= r_beat + BEAT_W'(1);
          end
        end

        ST_WAIT: begin
          // The first WAIT edge is exactly the end of the initiator's
          // turnaround for both reads and writes, so ownership starts here.
          r_drive <= 1'b1;
          if (w_lat_done) begin
            r_cmd <= C2_RESPONSE;
            if (r_is_write) begin
              r_data  <= {DATA_W{1'b0}};
              r_state <= ST_ACK;
            end else begin
              r_data  <= w_rd_line[DATA_W-1:0];
              r_buf   <= w_rd_line >> DATA_W;
              r_beat  <= {BEAT_W{1'b0}};
              r_state <= ST_SEND;
            end
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_cmd  <= C2_NOP;
            r_data <= {DATA_W{1'b0}};
          end
        end

        ST_SEND: begin
          if (r_beat == BEAT_W'(BEATS - 1)) begin
            r_state      <= ST_IDLE;
            r_drive      <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd        <= C2_NOP;
            r_data       <= {DATA_W{1'b0}};
            r_read_count <= r_read_count + 32'd1;
          end else begin
            r_beat <= r_beat + BEAT_W'(1);
            r_data <= r_buf[DATA_W-1:0];
            r_buf  <= r_buf >> DATA_W;
          end
        end

        ST_ACK: begin
          r_state       <= ST_IDLE;
          r_drive       <= 1'b0;
          r_busy        <= 1'b0;
          r_cmd         <= C2_NOP;
          r_write_count <= r_write_count + 32'd1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
          r_cmd   <= C2_NOP;
          r_data  <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign read_count    = r_read_count;
  assign write_count   = r_write_count;
  assign bus.slv_drive = r_drive;
  assign bus.slv_cmd   = r_cmd;
  assign bus.slv_data  = r_data;

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the C2 line bus: the device at the far end of the cache's memory port. It accepts READ_LINE and WRITE_LINE requests, holds the line store, and applies a fixed access latency. It then answers with a RESPONSE, which carries the line beat-by-beat on a read. It replaces the behavioural memory model in cache benches and is written to be synthesizable.

## Interface
Parameters:
- ADDR_W, 14, line-address width (tag+set bits on addr2 bus)
- DATA_W, 16, C2 data bus width in bits
- LINE_BYTES, 16, cache line size; BEATS = LINE_BYTES*8/DATA_W (8 by default)
- LATENCY, 100, cycles from request sample to first RESPONSE cycle; must be >= BEATS+1

Ports:
- clk  in  1  single clock, all sampling on posedge
- reset  in  1  asynchronous, active-low
- addr_mem_w  in  ADDR_W  line address from initiator
- data_mem_w  inout  DATA_W  line data beats; driven only while responder owns bus, else high-Z
- cmd_mem_w  inout  2  C2 command (NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3); driven only while owning
- busy  out  1  responder holds a request (state != IDLE)
- read_count  out  32  completed READ_LINE transactions
- write_count  out  32  completed WRITE_LINE transactions

## Operation
- States: IDLE, RECV, WAIT, SEND, ACK.
- IDLE: a request is sampled at posedge k when cmd_mem_w is READ_LINE or WRITE_LINE. The request latches addr_mem_w and resets the latency counter to 1. NOP, RESPONSE, X and Z are ignored.
- READ_LINE: IDLE -> WAIT.
- WRITE_LINE: beat 0 is sampled together with the command at posedge k. IDLE -> RECV; beats 1..BEATS-1 are sampled at posedges k+1..k+BEATS-1. RECV -> WAIT after the last beat.
- Beat i maps to line bits [i*DATA_W +: DATA_W], with beat 0 as the least-significant chunk.
- WAIT: the latency counter increments each cycle. At count == LATENCY the FSM moves to SEND (read) or ACK (write).
- SEND: drives RESPONSE plus beat j on the bus for BEATS consecutive cycles, then -> IDLE and releases the bus.
- ACK: commits the write buffer into the store, drives RESPONSE for one cycle, then -> IDLE.
- Bus ownership (drive enable), taken after the initiator's turnaround:
  - Asserted after posedge k+1 for a read and after posedge k+BEATS for a write.
  - While owning but not responding, the responder drives cmd=NOP and data=0.
- Any cmd value seen while not IDLE is ignored; there is no queueing.
- Store: 2^ADDR_W lines, contents not cleared by reset. Lines never written read back as X in simulation.
- Counters increment on the last RESPONSE cycle and wrap at 2^32.

## Timing
- Reset (asserted low) takes effect asynchronously:
  - State -> IDLE, drive enable = 0 (both buses Z), busy = 0, counters = 0, write buffer discarded.
  - A write aborted before ACK leaves its line unchanged.
- Read, request at posedge k: RESPONSE and beat 0 are visible after posedge k+LATENCY. Beat j is visible after posedge k+LATENCY+j. The bus is released after posedge k+LATENCY+BEATS.
- Write, request at posedge k: RESPONSE is visible for exactly one cycle after posedge k+LATENCY. The line is committed at that edge and the bus is released after posedge k+LATENCY+1.
- busy is high from after posedge k until the bus release edge.
- The earliest next request is sampled at the release edge + 1 (one-cycle turnaround).
- A read issued after a write to the same line returns the new data.

## Structure
- Shared package (c2_pkg / parameters package): the C2_NOP, C2_RESPONSE, C2_READ_LINE and C2_WRITE_LINE encodings; the default bus widths, line size and LATENCY. These are the same constants the cache and memory driver use.
- The FSM state enum lives locally.
- One sub-module, mem_line_ram: single-port, line-wide, one write port and one combinational read port. It has no reset.
- Top level: FSM, latency counter, beat counter, write shift buffer, tri-state drivers.

## Test plan
- Write then read back:
  - WRITE_LINE addr 0x0012, beats 0x0100..0x0107 at posedge k; RESPONSE exactly 1 cycle after posedge k+100; bus Z after k+101.
  - READ_LINE 0x0012 at posedge m; beats 0x0100..0x0107 after posedges m+100..m+107; read_count = 1, write_count = 1.
- Line isolation: write 0x0000 = all 0xAAAA and 0x3FFF = all 0x5555. Reading both returns the exact patterns with no aliasing at the address extremes.
- Reset mid-WAIT:
  - Write to 0x0040 with pattern A, then write 0x0040 with pattern B and assert reset low at k+50.
  - Required response: cmd/data go Z immediately, busy = 0, counters = 0, no RESPONSE.
  - A read of 0x0040 afterwards returns A.
- Ignored traffic: drive RESPONSE and NOP while idle, then READ_LINE during WAIT of a prior read. Exactly one response is produced, busy is never dropped mid-transaction, and read_count = 1.
- Back-to-back: a read issued at the release edge + 1 is accepted and its latency is measured from that edge.
